pc_gen_rv32i: RTL
=================

// Module: pc_gen_rv32i
// PURPOSE
//  Parametrised program-counter unit for the RV32I core: holds the current PC and computes the next PC.
//  Sources, by priority: trap vector, branch/jump redirect, stall hold, sequential increment.
//  Drives a valid/ready fetch request to instruction memory and flags misaligned redirect targets.
//  Sits between the branch/trap logic and the instruction-memory port, in the slot of the plain PC register.
// PARAMETERS
//  XLEN          32            PC / address width in bits
//  RESET_VECTOR  32'h00000000  PC value loaded by reset (XLEN bits)
//  INC           4             sequential increment in bytes
//  ALIGN_BITS    2             low PC bits that must be zero (1 when compressed ISA is enabled)
//  CNT_W         32            width of the accepted-fetch counter
// PORTS
//  clock            in   1      system clock, all state updates on rising edge
//  reset            in   1      synchronous, active-high reset
//  stall            in   1      hold PC (pipeline back-pressure)
//  halt             in   1      request to stop fetching
//  redirect_valid   in   1      branch/jump taken this cycle
//  redirect_target  in   XLEN   branch/jump target address
//  trap_valid       in   1      exception/interrupt taken this cycle
//  trap_vector      in   XLEN   trap handler address; low ALIGN_BITS are masked to 0
//  fetch_ready      in   1      instruction memory accepts request
//  fetch_valid      out  1      fetch request valid
//  fetch_addr       out  XLEN   current PC / fetch address
//  misalign         out  1      one-cycle pulse: rejected misaligned redirect
//  misalign_addr    out  XLEN   offending target, held until next misalign
//  fetch_count      out  CNT_W  number of accepted fetches (valid & ready), wraps mod 2^CNT_W
//  pc_state         out  2      0 = RST, 1 = RUN, 2 = HALT
// BEHAVIOUR
//  Reset (reset=1 at rising edge, any state, mid-handshake included):
//   fetch_addr=RESET_VECTOR, state=RST, fetch_valid=0, misalign=0, misalign_addr=0, fetch_count=0.
//  RST:
//   - Lasts exactly one cycle after reset deasserts, then goes to RUN.
//   - PC held; trap, redirect and halt are ignored.
//  RUN: fetch_valid=1. Next-PC selection, first match wins:
//   1. trap_valid: PC <= trap_vector & ~((1<<ALIGN_BITS)-1).
//   2. redirect_valid, target low ALIGN_BITS all zero: PC <= redirect_target.
//   3. redirect_valid, target misaligned: PC held; misalign=1 next cycle; misalign_addr <= target; state <= HALT.
//   4. halt: PC held; state <= HALT.
//   5. stall: PC held.
//   6. fetch_ready: PC <= PC + INC, wrapping mod 2^XLEN (e.g. 32'hFFFFFFFC -> 0).
//   7. otherwise: PC held (pending request; fetch_addr must stay stable).
//  Handshake:
//   - A request is accepted when fetch_valid & fetch_ready; fetch_count increments by 1 on every accepted request.
//   - An acceptance counts even when the same edge loads a trap or redirect PC; the PC still takes the new address.
//   - Trap/redirect may change fetch_addr while a request is pending (flush); nothing else may.
//  HALT:
//   - fetch_valid=0; PC held; fetch_count frozen.
//   - trap_valid loads the masked trap vector and goes to RUN.
//   - A valid, aligned redirect loads its target and goes to RUN.
//   - A misaligned redirect in HALT re-pulses misalign and stays in HALT.
//   - halt and stall have no effect in HALT.
//  Latency: a new PC is visible on fetch_addr the cycle after the redirect or trap. No combinational input->output paths.
//  misalign is high for exactly one cycle per rejected redirect.
// TESTING
//  - reset 1 for 2 cycles, then 0, fetch_ready=1 -> cycle 1 RST, fetch_valid=0, addr 0x0; then 0x0,0x4,0x8; fetch_count=3 after 3 cycles.
//  - RUN at 0x10, fetch_ready=0 for 3 cycles -> addr stays 0x10, count unchanged; ready=1 -> 0x14 next cycle.
//  - At 0x20: trap_valid=1 vector 0x103 plus redirect_valid=1 target 0x40 in the same cycle -> addr 0x100 next cycle.
//  - redirect_target 0x42 at ALIGN_BITS=2 -> misalign pulse 1 cycle, misalign_addr 0x42, HALT, fetch_valid=0; redirect 0x80 -> RUN at 0x80.
//  - PC 0xFFFFFFFC with ready=1 -> wraps to 0x0; stall=1 with ready=1 -> PC held, count still increments.
//  - reset=1 mid-pending request (addr 0x50, ready=0) -> next cycle addr 0x0, state RST, count 0.

Source files
------------

// File: rtl/pc_gen_rv32i.sv
// Program-counter unit for the RV32I core: holds the PC, selects the next PC
// (trap > redirect > halt > stall > increment) and drives the fetch handshake.
module pc_gen_rv32i #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_addr,
    output logic             misalign,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_count,
    output logic [1:0]       pc_state
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] trap_pc;
    logic            target_misaligned;
    logic            accept;

    assign trap_pc           = trap_vector & ~ALIGN_MASK;
    assign target_misaligned = |(redirect_target & ALIGN_MASK);
    assign accept            = fetch_valid & fetch_ready;
    assign pc_state          = state;

    // fetch_valid tracks state==RUN; misalign is a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RST;
            fetch_valid   <= 1'b0;
            fetch_addr    <= RESET_VECTOR;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            fetch_count   <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                ST_RST: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (accept) begin
                        fetch_count <= fetch_count + CNT_W'(1);
                    end
                    if (trap_valid) begin
                        fetch_addr <= trap_pc;
                    end else if (redirect_valid && !target_misaligned) begin
                        fetch_addr <= redirect_target;
                    end else if (redirect_valid) begin
                        misalign      <= 1'b1;
                        misalign_addr <= redirect_target;
                        state         <= ST_HALT;
                        fetch_valid   <= 1'b0;
                    end else if (halt) begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                    end else if (!stall && fetch_ready) begin
                        fetch_addr <= fetch_addr + XLEN'(INC);
                    end
                end
                ST_HALT: begin
                    if (trap_valid) begin
                        fetch_addr  <= trap_pc;
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                    end else if (redirect_valid && !target_misaligned) begin
                        fetch_addr  <= redirect_target;
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                    end else if (redirect_valid) begin
                        misalign      <= 1'b1;
                        misalign_addr <= redirect_target;
                    end
                end
                default: begin
                    state       <= ST_RST;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
